// File: rtl/riscv_mem_pkg.sv
// Shared types and helpers for the core-side store buffer.
package riscv_mem_pkg;

  localparam int unsigned SB_DEPTH_DEFAULT = 4;
  localparam int unsigned SB_AW            = 32;
  localparam int unsigned SB_DW            = 32;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:2] wadr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  // Ceiling log2 for pointer widths, evaluated at elaboration.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sb_fwd_sel.sv
// Youngest-match store-to-load forwarding selector over the store buffer entries.
module sb_fwd_sel
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  sb_entry_t                  entries [DEPTH],
  input  logic [clog2(DEPTH)-1:0]    head,
  input  logic [AW-1:2]              wadr,
  output logic                       hit,
  output logic [DW-1:0]              data
);

  localparam int unsigned PW = clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to youngest from head; a later match overrides, so the youngest store wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (entries[idx].valid && (entries[idx].wadr == (SB_AW-2)'(wadr))) begin
        hit  = 1'b1;
        data = DW'(entries[idx].data);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the single-cycle core data port and a valid/ready data RAM.
// Define STORE_BUF_FWD_EN to forward buffered stores to loads; otherwise loads read the RAM only.
module store_buffer
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
  parameter int unsigned AW    = SB_AW,
  parameter int unsigned DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWrite,
  input  logic [AW-1:0] DataAdr,
  input  logic [DW-1:0] WriteData,
  output logic [DW-1:0] ReadData,
  output logic          mem_wvalid,
  input  logic          mem_wready,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          sb_full,
  output logic          sb_empty,
  output logic          sb_overflow
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  sb_entry_t     entries [DEPTH];
  logic          overflow;
  logic          push;
  logic          pop;

  assign sb_full     = (count == CW'(DEPTH));
  assign sb_empty    = (count == '0);
  assign sb_overflow = overflow;
  assign mem_wvalid  = ~sb_empty;
  assign pop         = mem_wvalid & mem_wready;
  assign push        = MemWrite & (~sb_full | pop);
  assign mem_waddr   = {(AW-2)'(entries[head].wadr), 2'b00};
  assign mem_wdata   = DW'(entries[head].data);
  assign mem_raddr   = DataAdr;

  // Pop clears before push sets, so a full-FIFO push/pop on the same slot keeps the new entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else begin
      if (pop) begin
        entries[head].valid <= 1'b0;
        head                <= head + PW'(1);
      end
      if (push) begin
        entries[tail].valid <= 1'b1;
        entries[tail].wadr  <= (SB_AW-2)'(DataAdr[AW-1:2]);
        entries[tail].data  <= SB_DW'(WriteData);
        tail                <= tail + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      if (MemWrite && sb_full && !pop) overflow <= 1'b1;
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  sb_fwd_sel #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fwd_sel (
    .entries (entries),
    .head    (head),
    .wadr    (DataAdr[AW-1:2]),
    .hit     (fwd_hit),
    .data    (fwd_data)
  );

  assign ReadData = fwd_hit ? fwd_data : mem_rdata;
`else
  assign ReadData = mem_rdata;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected RAM writes queued at store time, checked by a monitor.
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        sb_full;
  logic        sb_empty;
  logic        sb_overflow;

`ifdef STORE_BUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  total;
  int  passed;
  int  wr_seen;

  store_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite    (MemWrite),
    .DataAdr     (DataAdr),
    .WriteData   (WriteData),
    .ReadData    (ReadData),
    .mem_wvalid  (mem_wvalid),
    .mem_wready  (mem_wready),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .sb_full     (sb_full),
    .sb_empty    (sb_empty),
    .sb_overflow (sb_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit accept);
    wr_t w;
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    if (accept) begin
      w.a = a;
      w.d = d;
      exp_q.push_back(w);
    end
    tick();
    MemWrite = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    exp_q.delete();
    tick();
  endtask

  task automatic wait_empty(input int limit, input bit rnd);
    int n;
    n = 0;
    while (!sb_empty && n < limit) begin
      mem_wready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    mem_wready = 1'b0;
    chk("drain_done", 32'(sb_empty), 32'd1);
    chk("all_writes_seen", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every RAM handshake must match the oldest outstanding store.
  always @(negedge clk) begin
    if (!reset && mem_wvalid && mem_wready) begin
      wr_t e;
      wr_seen++;
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL ram_write: unexpected addr %h data %h (t=%0t)", mem_waddr, mem_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        if (mem_waddr === e.a && mem_wdata === e.d) passed++;
        else $display("FAIL ram_write: got %h/%h expected %h/%h (t=%0t)",
                      mem_waddr, mem_wdata, e.a, e.d, $time);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int seen0;
    total      = 0;
    passed     = 0;
    wr_seen    = 0;
    reset      = 1'b1;
    MemWrite   = 1'b0;
    DataAdr    = '0;
    WriteData  = '0;
    mem_wready = 1'b0;
    mem_rdata  = '0;
    #12;
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_empty", 32'(sb_empty), 32'd1);
    chk("rst_full", 32'(sb_full), 32'd0);
    chk("rst_wvalid", 32'(mem_wvalid), 32'd0);
    chk("rst_overflow", 32'(sb_overflow), 32'd0);

    // Single store with stalled RAM: visible next cycle, then held
    MemWrite  = 1'b1;
    DataAdr   = 32'h60;
    WriteData = 32'd7;
    begin
      wr_t w;
      w.a = 32'h60;
      w.d = 32'd7;
      exp_q.push_back(w);
    end
    #1;
    chk("no_fallthrough", 32'(mem_wvalid), 32'd0);
    tick();
    MemWrite = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("hold_wvalid", 32'(mem_wvalid), 32'd1);
      chk("hold_waddr", mem_waddr, 32'h60);
      chk("hold_wdata", mem_wdata, 32'd7);
      tick();
    end
    wait_empty(10, 1'b0);

    // Fill, overflow drop, in-order drain
    for (int i = 0; i < 4; i++) store(32'h40 + 32'(4 * i), 32'h100 + 32'(i), 1'b1);
    chk("fill_full", 32'(sb_full), 32'd1);
    chk("fill_no_ovf", 32'(sb_overflow), 32'd0);
    store(32'h70, 32'hdead, 1'b0);
    chk("ovf_set", 32'(sb_overflow), 32'd1);
    chk("ovf_still_full", 32'(sb_full), 32'd1);
    chk("ovf_head", mem_waddr, 32'h40);
    wait_empty(20, 1'b0);
    chk("ovf_sticky", 32'(sb_overflow), 32'd1);

    // Full + store + pop in the same cycle
    do_reset();
    chk("rst_ovf_clear", 32'(sb_overflow), 32'd0);
    for (int i = 0; i < 4; i++) store(32'h40 + 32'(4 * i), 32'h100 + 32'(i), 1'b1);
    mem_wready = 1'b1;
    store(32'h50, 32'h150, 1'b1);
    mem_wready = 1'b0;
    chk("swap_full", 32'(sb_full), 32'd1);
    chk("swap_no_ovf", 32'(sb_overflow), 32'd0);
    chk("swap_head_addr", mem_waddr, 32'h44);
    chk("swap_head_data", mem_wdata, 32'h101);
    wait_empty(20, 1'b0);

    // Forwarding: youngest match, miss, head-being-popped
    store(32'h64, 32'd5, 1'b1);
    store(32'h64, 32'd25, 1'b1);
    DataAdr   = 32'h64;
    mem_rdata = 32'h0;
    #1;
    chk("fwd_young", ReadData, FWD ? 32'd25 : 32'h0);
    chk("raddr", mem_raddr, 32'h64);
    DataAdr   = 32'h68;
    mem_rdata = 32'h1234;
    #1;
    chk("fwd_miss", ReadData, 32'h1234);
    chk("raddr_miss", mem_raddr, 32'h68);
    DataAdr    = 32'h64;
    mem_rdata  = 32'haaaa;
    mem_wready = 1'b1;
    #1;
    chk("fwd_pop_old", ReadData, FWD ? 32'd25 : 32'haaaa);
    tick();
    chk("fwd_pop_head", ReadData, FWD ? 32'd25 : 32'haaaa);
    tick();
    chk("fwd_drained", ReadData, 32'haaaa);
    wait_empty(10, 1'b0);

    // Asynchronous reset mid-drain
    do_reset();
    store(32'h80, 32'h1, 1'b1);
    store(32'h84, 32'h2, 1'b1);
    store(32'h88, 32'h3, 1'b1);
    chk("pre_rst_wvalid", 32'(mem_wvalid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_wvalid", 32'(mem_wvalid), 32'd0);
    chk("async_empty", 32'(sb_empty), 32'd1);
    chk("async_full", 32'(sb_full), 32'd0);
    exp_q.delete();
    reset = 1'b0;
    seen0 = wr_seen;
    mem_wready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    mem_wready = 1'b0;
    chk("no_writes_after_rst", 32'(wr_seen - seen0), 32'd0);

    // Pointer wrap over 10 rounds with random backpressure
    do_reset();
    n = 0;
    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < (r % 4) + 1; j++) begin
        mem_wready = 1'($urandom_range(0, 1));
        store(32'h200 + 32'(4 * n), 32'(n * 17 + r), 1'b1);
        n++;
      end
      wait_empty(100, 1'b1);
    end
    chk("wrap_no_ovf", 32'(sb_overflow), 32'd0);

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
